tft_window_sequencer: RTL and testbench
=======================================

# tft_window_sequencer

Sequences draw operations onto the TFT SPI link after panel initialization. Accepts a rectangular window request, emits the CASET/RASET/RAMWR command and parameter words with the correct RS level, then streams exactly the window's pixel count from a pixel source to the SPI word interface. Sits between the frame/graphics logic and the SPI word serializer, replacing the free-running data path once `InitDone` is high.

## Interface
- `WIDTH`, 128: panel columns.
- `HEIGHT`, 160: panel rows.
- `CMD_CASET`, 16'h002A: column-address-set command word.
- `CMD_RASET`, 16'h002B: row-address-set command word.
- `CMD_RAMWR`, 16'h002C: memory-write command word.
- `MasterCLK` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `InitDone` input 1: panel init sequence finished; the level is held high thereafter.
- `ReqValid` input 1: window request valid.
- `ReqReady` output 1: window request accepted when both are high.
- `ReqX0`, `ReqX1` input 8: first and last column, inclusive.
- `ReqY0`, `ReqY1` input 8: first and last row, inclusive.
- `PixData` input 16: RGB565 pixel.
- `PixValid` input 1: pixel valid.
- `PixReady` output 1: pixel consumed when both are high.
- `OutData` output 16: word to the SPI serializer.
- `OutRS` output 1: 0 = command, 1 = data.
- `OutValid` output 1: word valid.
- `OutReady` input 1: serializer takes the word when both are high.
- `Busy` output 1: a window is in progress.
- `FrameDone` output 1: one-cycle pulse after the last pixel transfers.
- `Error` output 1: one-cycle pulse when a request is rejected.

## Operation
- FSM states: `IDLE`, `CASET`, `XS`, `XE`, `RASET`, `YS`, `YE`, `RAMWR`, `PIXELS`.
- **IDLE.** `ReqReady` = `InitDone`.
  - On accept, latch the coordinates and compute `PixTotal = (X1-X0+1)*(Y1-Y0+1)` as a 16-bit value (max 20480).
  - Then go to `CASET`.
- **Reject rule.** A request with `X1<X0` or `Y1<Y0` is accepted, `Error` pulses, and the FSM stays in `IDLE`. No words are emitted.
- **Command/parameter words.** Words are emitted in this order, each advancing state only on an `OutValid && OutReady` transfer:
  - `CASET`: `CMD_CASET`, RS=0.
  - `XS`: {8'h00, X0}, RS=1.
  - `XE`: {8'h00, X1}, RS=1.
  - `RASET`: `CMD_RASET`, RS=0.
  - `YS`: {8'h00, Y0}, RS=1.
  - `YE`: {8'h00, Y1}, RS=1.
  - `RAMWR`: `CMD_RAMWR`, RS=0.
- **PIXELS.** Combinational pass-through:
  - `OutData` = `PixData`, `OutRS` = 1, `OutValid` = `PixValid`, `PixReady` = `OutReady`.
  - The pixel counter increments per transfer.
  - On the transfer with counter = `PixTotal-1`: `FrameDone` pulses next cycle, the counter clears, and the FSM returns to `IDLE`.
- **Outside PIXELS.** `PixReady` = 0.
- **Busy.** `Busy` = 1 in every state except `IDLE`.
- **Reset.** Values after reset:
  - FSM = `IDLE`, counter = 0.
  - `OutData` = 0, `OutRS` = 0, `OutValid` = 0.
  - `ReqReady` = 0 until `InitDone`.
  - `PixReady` = 0, `Busy` = 0, `FrameDone` = 0, `Error` = 0.
- **Reset mid-window.** The window is aborted: no `FrameDone`, remaining pixels are not consumed, and latched coordinates are discarded.
- **`InitDone` low.** No requests are accepted. A request held valid waits.

## Timing
- Accept in cycle N puts `CASET` on the outputs in cycle N+1 with `OutValid` = 1 (registered).
- With `OutReady` held high:
  - 7 command/parameter words take 7 cycles.
  - The first pixel can transfer in cycle N+8.
  - A 1×1 window finishes at N+8; `FrameDone` pulses at N+9.
  - `ReqReady` is high again at N+9.
- Command-phase `OutData`/`OutRS` are registered and held stable while `OutValid && !OutReady`.
- Pixel phase adds zero latency: `PixData` is visible on `OutData` in the same cycle.
- Back-to-back requests: the next request can be accepted in the cycle `FrameDone` is high.
- `Error` pulses in the cycle after the rejected accept.

## Configuration
- **`TFT_WINDOW_CLIP_EN` defined.** Accepted coordinates are clamped before latching:
  - `X0`, `X1` are clamped to `WIDTH-1`; `Y0`, `Y1` are clamped to `HEIGHT-1`.
  - `PixTotal` is computed from the clamped values.
  - The reject rule applies after clamping.
- **`TFT_WINDOW_CLIP_EN` undefined.** Coordinates pass unmodified. Out-of-range windows are the requester's responsibility.

## Structure
- A shared package `tft_pkg` holds:
  - the FSM state enum;
  - the command constants `CMD_CASET`, `CMD_RASET`, `CMD_RAMWR`;
  - the default `WIDTH`/`HEIGHT`.
- One sub-module, `tft_pixel_counter`:
  - loads `PixTotal`, decrements on transfer, asserts `Last`;
  - is reusable by the frame logic.

## Test plan
- **Init gating.** `InitDone` = 0 with `ReqValid` = 1 for 20 cycles → `ReqReady` stays 0 and no `OutValid`. Raise `InitDone` → accept next cycle.
- **Full sequence, 2×2 window.** Window (0,0)-(1,1), `OutReady` = 1, `PixValid` = 1.
  - Words: 002A/0, 0000/1, 0001/1, 002B/0, 0000/1, 0001/1, 002C/0, then 4 pixels/1.
  - `FrameDone` pulses once; `Busy` falls with it.
- **Backpressure.** `OutReady` toggles 1010… during the command phase → each word is held stable until transferred, with no duplicates or skips.
- **Reject.** X0 = 5, X1 = 3 → `Error` pulses 1 cycle, no output words, FSM in `IDLE`.
- **Clip (`TFT_WINDOW_CLIP_EN`).** Window (120,150)-(200,200) → XE = 007F, YE = 009F, `PixTotal` = 80.
- **Mid-frame reset.** `reset` at pixel 3 of 16 → all outputs at reset values next cycle. A new request then completes normally.

Source files
------------

// File: rtl/tft_window_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_pkg
// Brief    : Shared TFT sequencer types: FSM states, panel command words and
//            default panel geometry, plus coordinate/area helpers.
// Revision : 1.0 - initial release
// ============================================================================
package tft_pkg;

   localparam int WIDTH  = 128;
   localparam int HEIGHT = 160;

   localparam logic [15:0] CMD_CASET = 16'h002A;
   localparam logic [15:0] CMD_RASET = 16'h002B;
   localparam logic [15:0] CMD_RAMWR = 16'h002C;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      CASET  = 4'd1,
      XS     = 4'd2,
      XE     = 4'd3,
      RASET  = 4'd4,
      YS     = 4'd5,
      YE     = 4'd6,
      RAMWR  = 4'd7,
      PIXELS = 4'd8
   } state_t;

   function automatic logic [7:0] clampCoord(input logic [7:0] v, input logic [7:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Area wraps modulo 2^16; a 256x256 window loads 0, which the counter
   // still runs as 65536 transfers.
   function automatic logic [15:0] windowArea(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] b0, input logic [7:0] b1);
      logic [15:0] w;
      logic [15:0] h;
      w = {8'h00, a1} - {8'h00, a0} + 16'd1;
      h = {8'h00, b1} - {8'h00, b0} + 16'd1;
      return w * h;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tft_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tft_window_sequencer_if
// Brief    : Request, pixel-source and SPI-word handshake bundle for the
//            window sequencer. master = requester/source/serializer side.
// Revision : 1.0 - initial release
// ============================================================================
interface tft_window_sequencer_if;

   logic        ReqValid;
   logic        ReqReady;
   logic [7:0]  ReqX0;
   logic [7:0]  ReqX1;
   logic [7:0]  ReqY0;
   logic [7:0]  ReqY1;

   logic [15:0] PixData;
   logic        PixValid;
   logic        PixReady;

   logic [15:0] OutData;
   logic        OutRS;
   logic        OutValid;
   logic        OutReady;

   modport master (
      output ReqValid, ReqX0, ReqX1, ReqY0, ReqY1,
      output PixData, PixValid,
      output OutReady,
      input  ReqReady, PixReady,
      input  OutData, OutRS, OutValid
   );

   modport slave (
      input  ReqValid, ReqX0, ReqX1, ReqY0, ReqY1,
      input  PixData, PixValid,
      input  OutReady,
      output ReqReady, PixReady,
      output OutData, OutRS, OutValid
   );

endinterface
`default_nettype wire

// File: rtl/tft_window_sequencer_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module   : tft_pixel_counter
// Brief    : Remaining-pixel down counter; load total, decrement per transfer,
//            Last flags the final pixel of the window.
// Revision : 1.0 - initial release
// ============================================================================
module tft_pixel_counter (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        load,
   input  wire logic [15:0] loadValue,
   input  wire logic        dec,
   output logic             last
);

   logic [15:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 16'd0;
      end else if (load) begin
         r_count <= loadValue;
      end else if (dec) begin
         r_count <= r_count - 16'd1;
      end
   end

   assign last = (r_count == 16'd1);

endmodule
`default_nettype wire

// File: rtl/tft_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tft_window_sequencer
// Brief    : Emits CASET/RASET/RAMWR words for a window request, then streams
//            the window's pixels to the SPI word interface.
//            Optional macro TFT_WINDOW_CLIP_EN clamps coordinates to the panel.
// Revision : 1.0 - initial release
// ============================================================================
module tft_window_sequencer #(
   parameter int          WIDTH     = tft_pkg::WIDTH,
   parameter int          HEIGHT    = tft_pkg::HEIGHT,
   parameter logic [15:0] CMD_CASET = tft_pkg::CMD_CASET,
   parameter logic [15:0] CMD_RASET = tft_pkg::CMD_RASET,
   parameter logic [15:0] CMD_RAMWR = tft_pkg::CMD_RAMWR
) (
   input  wire logic             MasterCLK,
   input  wire logic             reset,
   input  wire logic             InitDone,
   tft_window_sequencer_if.slave bus,
   output logic                  Busy,
   output logic                  FrameDone,
   output logic                  Error
);

   import tft_pkg::*;

`ifdef TFT_WINDOW_CLIP_EN
   localparam bit c_clipEn = 1'b1;
`else
   localparam bit c_clipEn = 1'b0;
`endif

   localparam logic [7:0] c_maxX = 8'(WIDTH - 1);
   localparam logic [7:0] c_maxY = 8'(HEIGHT - 1);

   state_t      r_state;
   logic [7:0]  r_x0;
   logic [7:0]  r_x1;
   logic [7:0]  r_y0;
   logic [7:0]  r_y1;
   logic [15:0] r_outData;
   logic        r_outRS;
   logic        r_outValid;
   logic        r_frameDone;
   logic        r_error;

   logic [7:0]  w_x0;
   logic [7:0]  w_x1;
   logic [7:0]  w_y0;
   logic [7:0]  w_y1;
   logic [15:0] w_pixTotal;
   logic        w_reqReady;
   logic        w_reqFire;
   logic        w_reject;
   logic        w_accept;
   logic        w_cmdXfer;
   logic        w_pixXfer;
   logic        w_last;
   logic        w_inPixels;

   always_comb begin
      w_x0 = c_clipEn ? clampCoord(bus.ReqX0, c_maxX) : bus.ReqX0;
      w_x1 = c_clipEn ? clampCoord(bus.ReqX1, c_maxX) : bus.ReqX1;
      w_y0 = c_clipEn ? clampCoord(bus.ReqY0, c_maxY) : bus.ReqY0;
      w_y1 = c_clipEn ? clampCoord(bus.ReqY1, c_maxY) : bus.ReqY1;
   end

   assign w_pixTotal = windowArea(w_x0, w_x1, w_y0, w_y1);
   assign w_reqReady = (r_state == IDLE) && InitDone;
   assign w_reqFire  = bus.ReqValid && w_reqReady;
   assign w_reject   = (w_x1 < w_x0) || (w_y1 < w_y0);
   assign w_accept   = w_reqFire && !w_reject;
   assign w_inPixels = (r_state == PIXELS);
   assign w_cmdXfer  = r_outValid && bus.OutReady;
   assign w_pixXfer  = w_inPixels && bus.PixValid && bus.OutReady;

   tft_pixel_counter u_pixelCounter (
      .clk       (MasterCLK),
      .rst       (reset),
      .load      (w_accept),
      .loadValue (w_pixTotal),
      .dec       (w_pixXfer),
      .last      (w_last)
   );

   // Each command/parameter state preloads the next word on its own transfer,
   // so the registered word only changes when the serializer takes it.
   always_ff @(posedge MasterCLK) begin
      if (reset) begin
         r_state     <= IDLE;
         r_x0        <= 8'd0;
         r_x1        <= 8'd0;
         r_y0        <= 8'd0;
         r_y1        <= 8'd0;
         r_outData   <= 16'd0;
         r_outRS     <= 1'b0;
         r_outValid  <= 1'b0;
         r_frameDone <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         r_error     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_reqFire && w_reject) begin
                  r_error <= 1'b1;
               end else if (w_accept) begin
                  r_x0       <= w_x0;
                  r_x1       <= w_x1;
                  r_y0       <= w_y0;
                  r_y1       <= w_y1;
                  r_outData  <= CMD_CASET;
                  r_outRS    <= 1'b0;
                  r_outValid <= 1'b1;
                  r_state    <= CASET;
               end
            end
            CASET: begin
               if (w_cmdXfer) begin
                  r_outData <= {8'h00, r_x0};
                  r_outRS   <= 1'b1;
                  r_state   <= XS;
               end
            end
            XS: begin
               if (w_cmdXfer) begin
                  r_outData <= {8'h00, r_x1};
                  r_outRS   <= 1'b1;
                  r_state   <= XE;
               end
            end
            XE: begin
               if (w_cmdXfer) begin
                  r_outData <= CMD_RASET;
                  r_outRS   <= 1'b0;
                  r_state   <= RASET;
               end
            end
            RASET: begin
               if (w_cmdXfer) begin
                  r_outData <= {8'h00, r_y0};
                  r_outRS   <= 1'b1;
                  r_state   <= YS;
               end
            end
            YS: begin
               if (w_cmdXfer) begin
                  r_outData <= {8'h00, r_y1};
                  r_outRS   <= 1'b1;
                  r_state   <= YE;
               end
            end
            YE: begin
               if (w_cmdXfer) begin
                  r_outData <= CMD_RAMWR;
                  r_outRS   <= 1'b0;
                  r_state   <= RAMWR;
               end
            end
            RAMWR: begin
               if (w_cmdXfer) begin
                  r_outData  <= 16'd0;
                  r_outRS    <= 1'b0;
                  r_outValid <= 1'b0;
                  r_state    <= PIXELS;
               end
            end
            PIXELS: begin
               if (w_pixXfer && w_last) begin
                  r_frameDone <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_outValid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   // Pixel phase bypasses the output registers for zero added latency.
   assign bus.OutData  = w_inPixels ? bus.PixData  : r_outData;
   assign bus.OutRS    = w_inPixels ? 1'b1         : r_outRS;
   assign bus.OutValid = w_inPixels ? bus.PixValid : r_outValid;
   assign bus.PixReady = w_inPixels && bus.OutReady;
   assign bus.ReqReady = w_reqReady;

   assign Busy      = (r_state != IDLE);
   assign FrameDone = r_frameDone;
   assign Error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_tft_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_window_sequencer
// Brief    : Self-checking bench; expected word streams are built from window
//            coordinates and a random pixel list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_window_sequencer;
   import tft_pkg::*;

   logic MasterCLK = 1'b0;
   logic reset;
   logic InitDone;
   logic Busy;
   logic FrameDone;
   logic Error;

   int vectors     = 0;
   int miscompares = 0;

   tft_window_sequencer_if bus();

   tft_window_sequencer dut (
      .MasterCLK (MasterCLK),
      .reset     (reset),
      .InitDone  (InitDone),
      .bus       (bus.slave),
      .Busy      (Busy),
      .FrameDone (FrameDone),
      .Error     (Error)
   );

   always #5 MasterCLK = ~MasterCLK;

   function automatic int clipX(input int v);
`ifdef TFT_WINDOW_CLIP_EN
      return (v > WIDTH - 1) ? WIDTH - 1 : v;
`else
      return v;
`endif
   endfunction

   function automatic int clipY(input int v);
`ifdef TFT_WINDOW_CLIP_EN
      return (v > HEIGHT - 1) ? HEIGHT - 1 : v;
`else
      return v;
`endif
   endfunction

   // Presents one request and drives it to completion; b2b returns in the
   // FrameDone cycle so the next call's request lands in that same cycle.
   task automatic run_window(input int x0, input int x1, input int y0, input int y1,
                             input int rdyMode, input int pixPct, input bit b2b);
      int cx0, cx1, cy0, cy1, total, pos, pixIdx;
      bit rej, got, rdy, pv, holdValid, earlyFd, busyBad, pixRdyBad;
      logic [16:0] holdWord;
      logic [16:0] expQ[$];
      logic [15:0] pix[$];
      logic [15:0] p;
      cx0 = clipX(x0); cx1 = clipX(x1); cy0 = clipY(y0); cy1 = clipY(y1);
      rej = (cx1 < cx0) || (cy1 < cy0);
      bus.ReqX0 = 8'(x0); bus.ReqX1 = 8'(x1);
      bus.ReqY0 = 8'(y0); bus.ReqY1 = 8'(y1);
      bus.ReqValid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100; t++) begin
         #1;
         if (bus.ReqReady === 1'b1) got = 1'b1;
         @(posedge MasterCLK); #1;
         if (got) break;
      end
      bus.ReqValid = 1'b0;
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL accept_timeout ReqReady got %b required 1", bus.ReqReady);
         return;
      end
      if (rej) begin
         #4;
         vectors++;
         if ({Error, bus.OutValid, Busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reject_pulse Error/OutValid/Busy got %b required 100", {Error, bus.OutValid, Busy});
         end
         @(posedge MasterCLK); #4;
         vectors++;
         if ({Error, bus.OutValid, Busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reject_after Error/OutValid/Busy got %b required 000", {Error, bus.OutValid, Busy});
         end
         @(posedge MasterCLK); #1;
         return;
      end
      expQ.push_back({1'b0, CMD_CASET});
      expQ.push_back({1'b1, 8'h00, 8'(cx0)});
      expQ.push_back({1'b1, 8'h00, 8'(cx1)});
      expQ.push_back({1'b0, CMD_RASET});
      expQ.push_back({1'b1, 8'h00, 8'(cy0)});
      expQ.push_back({1'b1, 8'h00, 8'(cy1)});
      expQ.push_back({1'b0, CMD_RAMWR});
      total = (cx1 - cx0 + 1) * (cy1 - cy0 + 1);
      for (int i = 0; i < total; i++) begin
         p = 16'($urandom);
         pix.push_back(p);
         expQ.push_back({1'b1, p});
      end
      pos = 0; pixIdx = 0; holdValid = 0; holdWord = '0;
      earlyFd = 0; busyBad = 0; pixRdyBad = 0;
      for (int cyc = 0; cyc < 30 * (total + 7) + 100; cyc++) begin
         if (rdyMode == 0)      rdy = 1'b1;
         else if (rdyMode == 1) rdy = ((cyc % 2) == 0);
         else                   rdy = 1'($urandom_range(0, 1));
         pv = (pixIdx < total) && ($urandom_range(0, 99) < pixPct);
         bus.OutReady = rdy;
         bus.PixValid = pv;
         bus.PixData  = (pixIdx < total) ? pix[pixIdx] : 16'($urandom);
         #4;
         if (cyc == 0) begin
            vectors++;
            if ({bus.OutValid, bus.OutRS, bus.OutData} !== {2'b10, CMD_CASET}) begin
               miscompares++;
               $display("FAIL first_word valid/rs/data got %b/%b/%h required 1/0/%h",
                        bus.OutValid, bus.OutRS, bus.OutData, CMD_CASET);
            end
         end
         if (FrameDone !== 1'b0) earlyFd = 1'b1;
         if (Busy !== 1'b1) busyBad = 1'b1;
         if (pos < 7 && bus.PixReady !== 1'b0) pixRdyBad = 1'b1;
         if (holdValid) begin
            vectors++;
            if ({bus.OutRS, bus.OutData} !== holdWord) begin
               miscompares++;
               $display("FAIL hold_word got %h required %h", {bus.OutRS, bus.OutData}, holdWord);
            end
         end
         holdValid = 1'b0;
         if (bus.OutValid === 1'b1 && !rdy && pos < 7) begin
            holdValid = 1'b1;
            holdWord  = {bus.OutRS, bus.OutData};
         end
         if (bus.OutValid === 1'b1 && rdy) begin
            vectors++;
            if (pos >= expQ.size()) begin
               miscompares++;
               $display("FAIL extra_word got %h required none", {bus.OutRS, bus.OutData});
            end else if ({bus.OutRS, bus.OutData} !== expQ[pos]) begin
               miscompares++;
               $display("FAIL word[%0d] rs/data got %h required %h", pos, {bus.OutRS, bus.OutData}, expQ[pos]);
            end
            pos++;
         end
         if (pv && bus.PixReady === 1'b1) pixIdx++;
         @(posedge MasterCLK); #1;
         if (pos >= expQ.size()) break;
      end
      bus.PixValid = 1'b0;
      vectors++;
      if (pos != expQ.size()) begin
         miscompares++;
         $display("FAIL window_timeout words got %0d required %0d", pos, expQ.size());
         return;
      end
      vectors++;
      if (pixIdx != total) begin
         miscompares++;
         $display("FAIL pixels_consumed got %0d required %0d", pixIdx, total);
      end
      vectors++;
      if (earlyFd || busyBad || pixRdyBad) begin
         miscompares++;
         $display("FAIL window_flags earlyFrameDone/busyLow/pixReadyCmd got %b%b%b required 000",
                  earlyFd, busyBad, pixRdyBad);
      end
      #4;
      vectors++;
      if ({FrameDone, Busy, bus.ReqReady} !== 3'b101) begin
         miscompares++;
         $display("FAIL frame_done FrameDone/Busy/ReqReady got %b required 101", {FrameDone, Busy, bus.ReqReady});
      end
      if (b2b) return;
      @(posedge MasterCLK); #4;
      vectors++;
      if (FrameDone !== 1'b0) begin
         miscompares++;
         $display("FAIL frame_done_width got %b required 0", FrameDone);
      end
      @(posedge MasterCLK); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; InitDone = 1'b0;
      bus.ReqValid = 1'b0; bus.ReqX0 = '0; bus.ReqX1 = '0; bus.ReqY0 = '0; bus.ReqY1 = '0;
      bus.PixData = '0; bus.PixValid = 1'b0; bus.OutReady = 1'b0;
      repeat (3) @(posedge MasterCLK);
      #1 reset = 1'b0;
      #3;
      vectors++;
      if ({bus.ReqReady, bus.OutValid, bus.OutRS, bus.PixReady, Busy, FrameDone, Error} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b required 0000000",
                  {bus.ReqReady, bus.OutValid, bus.OutRS, bus.PixReady, Busy, FrameDone, Error});
      end
      vectors++;
      if (bus.OutData !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_outdata got %h required 0000", bus.OutData);
      end
      @(posedge MasterCLK); #1;
   endtask

   task automatic test_init_gating();
      bit bad;
      bad = 1'b0;
      InitDone = 1'b0;
      bus.ReqX0 = 8'd0; bus.ReqX1 = 8'd0; bus.ReqY0 = 8'd0; bus.ReqY1 = 8'd0;
      bus.ReqValid = 1'b1; bus.OutReady = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #4;
         if (bus.ReqReady !== 1'b0 || bus.OutValid !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
         @(posedge MasterCLK); #1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL init_gating activity got 1 required 0");
      end
      InitDone = 1'b1;
      #1;
      vectors++;
      if (bus.ReqReady !== 1'b1) begin
         miscompares++;
         $display("FAIL init_ready got %b required 1", bus.ReqReady);
      end
      run_window(0, 0, 0, 0, 0, 100, 1'b0);
   endtask

   task automatic test_full_2x2();
      run_window(0, 1, 0, 1, 0, 100, 1'b0);
   endtask

   task automatic test_backpressure();
      run_window(3, 6, 2, 4, 1, 100, 1'b0);
   endtask

   task automatic test_reject();
      run_window(5, 3, 0, 0, 0, 100, 1'b0);
      run_window(0, 0, 9, 2, 0, 100, 1'b0);
   endtask

   task automatic test_random_windows();
      int x0, x1, y0, y1, tmp;
      for (int n = 0; n < 12; n++) begin
         x0 = $urandom_range(0, 127); x1 = x0 + $urandom_range(0, 5);
         y0 = $urandom_range(0, 159); y1 = y0 + $urandom_range(0, 4);
         if (x1 > 127) x1 = 127;
         if (y1 > 159) y1 = 159;
         if ($urandom_range(0, 4) == 0 && x1 != x0) begin
            tmp = x0; x0 = x1; x1 = tmp;
         end
         run_window(x0, x1, y0, y1, 2, $urandom_range(30, 100), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      run_window(10, 11, 20, 21, 0, 100, 1'b1);
      run_window(0, 2, 0, 0, 2, 70, 1'b1);
      run_window(127, 127, 159, 159, 0, 100, 1'b0);
   endtask

`ifdef TFT_WINDOW_CLIP_EN
   task automatic test_clip();
      run_window(120, 200, 150, 200, 0, 100, 1'b0);
   endtask
`endif

   task automatic test_midframe_reset();
      int xfers;
      bit got, bad;
      bus.ReqX0 = 8'd0; bus.ReqX1 = 8'd3; bus.ReqY0 = 8'd0; bus.ReqY1 = 8'd3;
      bus.ReqValid = 1'b1; bus.OutReady = 1'b1; bus.PixValid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (bus.ReqReady === 1'b1) got = 1'b1;
         @(posedge MasterCLK); #1;
         if (got) break;
      end
      bus.ReqValid = 1'b0;
      xfers = 0;
      for (int c = 0; c < 40 && xfers < 10; c++) begin
         bus.PixData = 16'($urandom);
         #4;
         if (bus.OutValid === 1'b1) xfers++;
         @(posedge MasterCLK); #1;
      end
      reset = 1'b1;
      @(posedge MasterCLK); #4;
      vectors++;
      if ({bus.OutValid, bus.OutRS, bus.PixReady, Busy, FrameDone, Error} !== 6'b0 || bus.OutData !== 16'h0) begin
         miscompares++;
         $display("FAIL midframe_reset flags %b data %h required 000000 0000",
                  {bus.OutValid, bus.OutRS, bus.PixReady, Busy, FrameDone, Error}, bus.OutData);
      end
      @(posedge MasterCLK); #1;
      reset = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #4;
         if (FrameDone !== 1'b0 || bus.PixReady !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
         @(posedge MasterCLK); #1;
      end
      bus.PixValid = 1'b0;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL abort_quiet activity got 1 required 0");
      end
      run_window(4, 7, 8, 11, 2, 80, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_gating();
      test_full_2x2();
      test_backpressure();
      test_reject();
      test_random_windows();
      test_back_to_back();
`ifdef TFT_WINDOW_CLIP_EN
      test_clip();
`endif
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
